// File: rtl/sign_mag_converter_pkg.sv
// sign_mag_converter_pkg: FSM state encoding and default word width for the
// bit-serial two's-complement to sign-magnitude converter.
package sign_mag_converter_pkg;
    localparam int N_DEF = 4;
    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/sign_mag_converter_if.sv
// sign_mag_converter_if: word-in / result-out valid-ready bus.
//   in_valid/in_ready/in_data      two's-complement operand stream
//   out_valid/out_ready            result handshake
//   out_sign/out_mag               sign bit and N-bit magnitude
//   slave = converter side, master = producer/consumer side
interface sign_mag_converter_if #(parameter int N = 4);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [N-1:0] out_mag;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_mag
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_mag
    );
endinterface

// File: rtl/sign_mag_converter_serial_negate_cell.sv
// serial_negate_cell: LSB-first serial two's-complement negation bit.
//   clk, rst_n  clock, async active-low reset
//   clr         restart a new word (clears seen-one flag)
//   en          consume b_in this cycle
//   b_in        current operand bit
//   b_out       negated bit: copy until the first 1 is seen, invert afterwards
module serial_negate_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic b_in,
    output logic b_out
);
    logic seen_q;
    assign b_out = seen_q ^ b_in;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            seen_q <= 1'b0;
        else if (clr)
            seen_q <= 1'b0;
        else if (en)
            seen_q <= seen_q | b_in;
endmodule

// File: rtl/sign_mag_converter.sv
// sign_mag_converter: bit-serial N-bit two's-complement to sign-magnitude.
//   clk, rst_n  clock, async active-low reset
//   bus         sign_mag_converter_if.slave (in/out valid-ready streams)
// Positive words complete one cycle after accept; negative words are negated
// LSB-first over N cycles, the result bits entering the data register at the
// MSB end so that after N shifts it holds the magnitude.
module sign_mag_converter
    import sign_mag_converter_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic clk,
    input  logic rst_n,
    sign_mag_converter_if.slave bus
);
    localparam int CNTW = $clog2(N);
    state_t         state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N-1:0]   data_q, data_d;
    logic [N-1:0]   mag_q, mag_d;
    logic           sign_q, sign_d;
    logic           accept;
    logic           obit;
    assign bus.in_ready  = state_q == ST_IDLE;
    assign bus.out_valid = state_q == ST_DONE;
    assign bus.out_sign  = sign_q;
    assign bus.out_mag   = mag_q;
    assign accept        = bus.in_valid && state_q == ST_IDLE;
    serial_negate_cell u_neg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_q == ST_SHIFT),
        .b_in  (data_q[0]),
        .b_out (obit)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        case (state_q)
            ST_IDLE:
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    sign_d  = bus.in_data[N-1];
                    cnt_d   = '0;
                    mag_d   = bus.in_data[N-1] ? mag_q : bus.in_data;
                    state_d = bus.in_data[N-1] ? ST_SHIFT : ST_DONE;
                end
            ST_SHIFT: begin
                data_d = {obit, data_q[N-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNTW'(N - 1)) begin
                    mag_d   = {obit, data_q[N-1:1]};
                    state_d = ST_DONE;
                end
            end
            ST_DONE:
                state_d = bus.out_ready ? ST_IDLE : ST_DONE;
            default:
                state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
        end
endmodule

// File: tb/tb_sign_mag_converter.sv
// tb_sign_mag_converter: directed checks of the N=4 converter plus an
// exhaustive back-to-back sweep of an N=8 instance.
module tb_sign_mag_converter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    sign_mag_converter_if #(.N(4)) bus4 ();
    sign_mag_converter_if #(.N(8)) bus8 ();
    sign_mag_converter #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    sign_mag_converter #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept4(input logic [3:0] d);
        bus4.in_data  = d;
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid (1 = visible right after accept).
    task automatic wait_valid4(output int lat);
        lat = 1;
        while (!bus4.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release4();
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (bus4.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus4.in_ready); end
        checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus4.out_valid); end
        checks++; if (bus4.out_sign !== 1'b0) begin failures++; $display("FAIL rst_sign got=%b exp=0", bus4.out_sign); end
        checks++; if (bus4.out_mag !== 4'b0000) begin failures++; $display("FAIL rst_mag got=%b exp=0000", bus4.out_mag); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_positive();
        int lat;
        accept4(4'b0101);
        wait_valid4(lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL pos_latency got=%0d exp=1", lat); end
        checks++; if (bus4.out_sign !== 1'b0) begin failures++; $display("FAIL pos_sign got=%b exp=0", bus4.out_sign); end
        checks++; if (bus4.out_mag !== 4'b0101) begin failures++; $display("FAIL pos_mag got=%b exp=0101", bus4.out_mag); end
        checks++; if (bus4.in_ready !== 1'b0) begin failures++; $display("FAIL pos_in_ready_done got=%b exp=0", bus4.in_ready); end
        release4();
        checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL pos_out_valid_idle got=%b exp=0", bus4.out_valid); end
        checks++; if (bus4.in_ready !== 1'b1) begin failures++; $display("FAIL pos_in_ready_idle got=%b exp=1", bus4.in_ready); end
    endtask

    task automatic test_negative();
        int lat;
        accept4(4'b1011);
        lat = 1;
        while (!bus4.out_valid && lat < 20) begin
            checks++; if (bus4.in_ready !== 1'b0) begin failures++; $display("FAIL neg_in_ready_busy got=%b exp=0 cyc=%0d", bus4.in_ready, lat); end
            tick();
            lat++;
        end
        checks++; if (lat != 5) begin failures++; $display("FAIL neg_latency got=%0d exp=5", lat); end
        checks++; if (bus4.out_sign !== 1'b1) begin failures++; $display("FAIL neg_sign got=%b exp=1", bus4.out_sign); end
        checks++; if (bus4.out_mag !== 4'b0101) begin failures++; $display("FAIL neg_mag got=%b exp=0101", bus4.out_mag); end
        release4();
    endtask

    task automatic test_boundaries();
        int lat;
        accept4(4'b1000);
        wait_valid4(lat);
        checks++; if (bus4.out_valid !== 1'b1) begin failures++; $display("FAIL min_valid got=%b exp=1", bus4.out_valid); end
        checks++; if (bus4.out_sign !== 1'b1) begin failures++; $display("FAIL min_sign got=%b exp=1", bus4.out_sign); end
        checks++; if (bus4.out_mag !== 4'b1000) begin failures++; $display("FAIL min_mag got=%b exp=1000", bus4.out_mag); end
        release4();
        accept4(4'b1111);
        wait_valid4(lat);
        checks++; if (bus4.out_sign !== 1'b1) begin failures++; $display("FAIL m1_sign got=%b exp=1", bus4.out_sign); end
        checks++; if (bus4.out_mag !== 4'b0001) begin failures++; $display("FAIL m1_mag got=%b exp=0001", bus4.out_mag); end
        release4();
    endtask

    task automatic test_backpressure();
        int lat;
        accept4(4'b0011);
        wait_valid4(lat);
        bus4.in_data  = 4'b1111;
        bus4.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus4.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1 cyc=%0d", bus4.out_valid, i); end
            checks++; if (bus4.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0 cyc=%0d", bus4.in_ready, i); end
            checks++; if ({bus4.out_sign, bus4.out_mag} !== 5'b0_0011) begin failures++; $display("FAIL bp_hold got=%b exp=00011 cyc=%0d", {bus4.out_sign, bus4.out_mag}, i); end
        end
        bus4.in_valid = 1'b0;
        release4();
        checks++; if (bus4.in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle got=%b exp=1", bus4.in_ready); end
        checks++; if ({bus4.out_sign, bus4.out_mag} !== 5'b0_0011) begin failures++; $display("FAIL bp_idle_hold got=%b exp=00011", {bus4.out_sign, bus4.out_mag}); end
    endtask

    task automatic test_mid_reset();
        int lat;
        accept4(4'b1010);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus4.in_ready !== 1'b1) begin failures++; $display("FAIL mr_in_ready got=%b exp=1", bus4.in_ready); end
        checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL mr_out_valid got=%b exp=0", bus4.out_valid); end
        checks++; if ({bus4.out_sign, bus4.out_mag} !== 5'b0_0000) begin failures++; $display("FAIL mr_outputs got=%b exp=00000", {bus4.out_sign, bus4.out_mag}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        accept4(4'b1110);
        wait_valid4(lat);
        checks++; if (lat != 5) begin failures++; $display("FAIL mr_latency got=%0d exp=5", lat); end
        checks++; if ({bus4.out_sign, bus4.out_mag} !== 5'b1_0010) begin failures++; $display("FAIL mr_result got=%b exp=10010", {bus4.out_sign, bus4.out_mag}); end
        release4();
    endtask

    task automatic test_back_to_back();
        bus4.out_ready = 1'b1;
        accept4(4'b0000);
        checks++; if ({bus4.out_valid, bus4.out_sign, bus4.out_mag} !== 6'b10_0000) begin failures++; $display("FAIL zero_result got=%b exp=100000", {bus4.out_valid, bus4.out_sign, bus4.out_mag}); end
        tick();
        checks++; if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin failures++; $display("FAIL zero_same_cycle_hs got=%b%b exp=10", bus4.in_ready, bus4.out_valid); end
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_exhaustive8();
        int lat;
        int m;
        logic [7:0] d;
        bus8.out_ready = 1'b1;
        for (int x = -128; x < 128; x++) begin
            d = 8'(x);
            m = x < 0 ? -x : x;
            bus8.in_data  = d;
            bus8.in_valid = 1'b1;
            tick();
            bus8.in_valid = 1'b0;
            lat = 1;
            while (!bus8.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            checks++; if (bus8.out_valid !== 1'b1) begin failures++; $display("FAIL ex8_timeout x=%0d got=%b exp=1", x, bus8.out_valid); end
            checks++; if (bus8.out_sign !== (x < 0)) begin failures++; $display("FAIL ex8_sign x=%0d got=%b exp=%b", x, bus8.out_sign, x < 0); end
            checks++; if (bus8.out_mag !== m[7:0]) begin failures++; $display("FAIL ex8_mag x=%0d got=%h exp=%h", x, bus8.out_mag, m[7:0]); end
            tick();
        end
    endtask

    initial begin
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b0;
        test_reset();
        test_positive();
        test_negative();
        test_boundaries();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_exhaustive8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
